// File: rtl/serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, behind a three-state
// IDLE/BUSY/DONE controller with registered status and result outputs.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             h1_s, h1_c, h2_s, h2_c;
  logic             c_next;
  logic [WIDTH-1:0] res_next;
  logic             last;

  // Full add as two half-add steps plus an OR.
  always_comb begin
    h1_s     = sh_a[0] ^ sh_b[0];
    h1_c     = sh_a[0] & sh_b[0];
    h2_s     = h1_s ^ carry;
    h2_c     = h1_s & carry;
    c_next   = h1_c | h2_c;
    res_next = (res >> 1) | (WIDTH'(h2_s) << (WIDTH - 1));
    last     = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          carry <= c_next;
          res   <= res_next;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= res_next;
            cout  <= c_next;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits (legal range 1..32).
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (BUSY state).
REQ-009 done  output  1  single-cycle pulse marking a valid result (DONE state).
REQ-010 sum  output  WIDTH  registered result, (a + b + cin) mod 2^WIDTH.
REQ-011 cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 IDLE with start=1 at an edge SHALL capture a, b and cin into internal shift/carry registers, clear the bit counter and move to BUSY.
REQ-014 IDLE with start=0 SHALL stay in IDLE.
REQ-015 BUSY SHALL process one bit per edge, LSB first: s = a_i ^ b_i ^ c; c_next = majority(a_i, b_i, c), built from two half-add steps plus an OR.
REQ-016 BUSY SHALL shift each result bit into an internal result register and increment the bit counter.
REQ-017 On the edge that processes bit WIDTH-1, the block SHALL load sum and cout from the internal registers and move to DONE.
REQ-018 DONE SHALL last exactly one cycle and then move unconditionally to IDLE.
REQ-019 Latency: done SHALL be high in the cycle that follows the WIDTH-th edge after the start-accepting edge.
REQ-020 Throughput: at most one addition per WIDTH+2 cycles.
REQ-021 busy SHALL equal (state==BUSY); done SHALL equal (state==DONE); both SHALL be registered and glitch-free.
REQ-022 start SHALL be ignored in BUSY and DONE; no queuing; captured operands SHALL remain unaffected.
REQ-023 Changes on a, b or cin outside the accepting edge SHALL have no effect.
REQ-024 sum and cout SHALL change only on entry to DONE and SHALL hold through later IDLE and BUSY cycles until the next result is loaded.
REQ-025 Overflow SHALL wrap modulo 2^WIDTH, with the lost bit reported on cout; no saturation.
REQ-026 WIDTH=1 SHALL work: one BUSY cycle, then DONE.
REQ-027 The bit counter SHALL be clog2(WIDTH+1) bits wide and SHALL never wrap during an operation.

Reset
REQ-028 While rst=1, state SHALL be IDLE and busy, done, sum, cout, the internal shift registers, the carry register and the bit counter SHALL all be 0.
REQ-029 rst asserted mid-operation SHALL abort immediately: no done pulse, and sum/cout SHALL be cleared to 0.
REQ-030 After rst deasserts, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031 Apply rst for 2 cycles, release -> busy=0, done=0, sum=0x00, cout=0; stays in IDLE with start=0.
REQ-032 a=0x0F, b=0x01, cin=0, start for 1 cycle -> busy high 8 cycles, then done=1 for exactly 1 cycle, sum=0x10, cout=0.
REQ-033 Run a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then run a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 Start a=0x12, b=0x34, then pulse start with a=0xAA, b=0xAA during BUSY -> ignored; single done pulse with sum=0x46, cout=0.
REQ-035 rst asserted on the 4th BUSY cycle -> busy=0, sum=0x00, no done. Next op a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1.
REQ-036 Random sweep of ≥1000 ops against a reference model (a+b+cin) -> every done carries a matching {cout,sum}; done count equals accepted start count.
